// File: rtl/rf_pkg.sv
// Shared constants and helpers for the regfile_sb register file and its scoreboard.
package rf_pkg;

  localparam int RF_WIDTH = 16;
  localparam int RF_DEPTH = 8;

  // Register contents after reset; sliced to WIDTH (WIDTH <= 64).
  localparam logic [63:0] RF_RST_VAL = 64'h0;

  // Select width for a given depth, never narrower than one bit.
  function automatic int sel_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending vector with issue/writeback set/clear and a sticky protocol error flag.
module rf_scoreboard import rf_pkg::*; #(
  parameter int DEPTH = RF_DEPTH,
  parameter int SEL_W = sel_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_en,
  input  logic [SEL_W-1:0] issue_sel,
  input  logic             write_en,
  input  logic [SEL_W-1:0] write_sel,
  output logic [DEPTH-1:0] pend_o,
  output logic             err_o
);

  logic [DEPTH-1:0] pend_q, pend_d;
  logic             err_q, err_d;
  logic [DEPTH-1:0] wr_dec, iss_dec;

  always_comb begin
    wr_dec  = '0;
    iss_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_dec[i]  = write_en && (write_sel == SEL_W'(i));
      iss_dec[i] = issue_en && (issue_sel == SEL_W'(i));
    end

    err_d = err_q;
    // An enable with no decoded register means the select was out of range.
    if (write_en && !(|wr_dec))          err_d = 1'b1;
    if (issue_en && !(|iss_dec))         err_d = 1'b1;
    if (|(wr_dec & ~pend_q))             err_d = 1'b1;
    // Re-issue is legal only when the old producer retires in the same cycle.
    if (|(iss_dec & pend_q & ~wr_dec))   err_d = 1'b1;

    pend_d = (pend_q & ~wr_dec) | iss_dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign pend_o = pend_q;
  assign err_o  = err_q;

endmodule

// File: rtl/regfile_sb.sv
// 1W/2R register file with scoreboard busy outputs.
// Optional same-cycle write-to-read bypass: define REGFILE_SB_BYPASS_EN.
module regfile_sb import rf_pkg::*; #(
  parameter  int WIDTH = RF_WIDTH,
  parameter  int DEPTH = RF_DEPTH,
  localparam int SEL_W = sel_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] read1RegSel,
  input  logic [SEL_W-1:0] read2RegSel,
  output logic [WIDTH-1:0] read1Data,
  output logic [WIDTH-1:0] read2Data,
  output logic             read1Busy,
  output logic             read2Busy,
  input  logic             writeEn,
  input  logic [SEL_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0] writeData,
  input  logic             issueEn,
  input  logic [SEL_W-1:0] issueRegSel,
  output logic [DEPTH-1:0] pendMask,
  output logic             err
);

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [WIDTH-1:0] reg_vec [DEPTH];
  logic [DEPTH-1:0] pend;

  rf_scoreboard #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .issue_en  (issueEn),
    .issue_sel (issueRegSel),
    .write_en  (writeEn),
    .write_sel (writeRegSel),
    .pend_o    (pend),
    .err_o     (err)
  );

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
      data_d = data_q;
      if (writeEn && (writeRegSel == SEL_W'(g))) data_d = writeData;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) data_q <= RF_RST_VAL[WIDTH-1:0];
      else     data_q <= data_d;
    end

    assign reg_vec[g] = data_q;
  end

  // Out-of-range selects match no register and fall through to 0 / not busy.
  always_comb begin
    read1Data = '0;
    read2Data = '0;
    read1Busy = 1'b0;
    read2Busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (read1RegSel == SEL_W'(i)) begin
        read1Data = reg_vec[i];
        read1Busy = pend[i];
        if (BYPASS_EN && !rst && writeEn && (writeRegSel == SEL_W'(i))) begin
          read1Data = writeData;
          read1Busy = pend[i] & issueEn & (issueRegSel == SEL_W'(i));
        end
      end
      if (read2RegSel == SEL_W'(i)) begin
        read2Data = reg_vec[i];
        read2Busy = pend[i];
        if (BYPASS_EN && !rst && writeEn && (writeRegSel == SEL_W'(i))) begin
          read2Data = writeData;
          read2Busy = pend[i] & issueEn & (issueRegSel == SEL_W'(i));
        end
      end
    end
  end

  assign pendMask = pend;

endmodule

// File: tb/tb_regfile_sb.sv
// Random + directed bench for regfile_sb; runs DEPTH=8 and DEPTH=6 instances in lockstep against a behavioural model.
module tb_regfile_sb;

  localparam int W  = 16;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          we = 1'b0, ie = 1'b0;
  logic [SW-1:0] wsel = '0, isel = '0, r1 = '0, r2 = '0;
  logic [W-1:0]  wdata = '0;

  logic [W-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic         b1_a, b2_a, b1_b, b2_b, err_a, err_b;
  logic [7:0]   pm_a;
  logic [5:0]   pm_b;

  regfile_sb #(.WIDTH(W), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .read1RegSel(r1), .read2RegSel(r2),
    .read1Data(rd1_a), .read2Data(rd2_a),
    .read1Busy(b1_a), .read2Busy(b2_a),
    .writeEn(we), .writeRegSel(wsel), .writeData(wdata),
    .issueEn(ie), .issueRegSel(isel),
    .pendMask(pm_a), .err(err_a)
  );

  regfile_sb #(.WIDTH(W), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst),
    .read1RegSel(r1), .read2RegSel(r2),
    .read1Data(rd1_b), .read2Data(rd2_b),
    .read1Busy(b1_b), .read2Busy(b2_b),
    .writeEn(we), .writeRegSel(wsel), .writeData(wdata),
    .issueEn(ie), .issueRegSel(isel),
    .pendMask(pm_b), .err(err_b)
  );

  // Reference model: index 0 is the DEPTH=8 instance, index 1 the DEPTH=6 one.
  int         dep [2] = '{8, 6};
  logic [W-1:0] m_reg [2][8];
  logic       m_pend [2][8];
  logic       m_err [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input int k, input logic [SW-1:0] sel);
    if (rst || sel >= dep[k]) return '0;
`ifdef REGFILE_SB_BYPASS_EN
    if (we && wsel == sel) return wdata;
`endif
    return m_reg[k][sel];
  endfunction

  function automatic logic exp_busy(input int k, input logic [SW-1:0] sel);
    logic b;
    if (rst || sel >= dep[k]) return 1'b0;
    b = m_pend[k][sel];
`ifdef REGFILE_SB_BYPASS_EN
    if (we && wsel == sel && !(ie && isel == sel)) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic [7:0] exp_pm(input int k);
    logic [7:0] v = '0;
    if (rst) return '0;
    for (int i = 0; i < dep[k]; i++) v[i] = m_pend[k][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_reg[k][i]  = '0;
        m_pend[k][i] = 1'b0;
      end
    end
  endtask

  // Applies the rules of one rising edge to the model using the current inputs.
  task automatic model_edge();
    bit wok, iok;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      wok = we && (wsel < dep[k]);
      iok = ie && (isel < dep[k]);
      if (we && !wok) m_err[k] = 1'b1;
      if (ie && !iok) m_err[k] = 1'b1;
      if (wok && !m_pend[k][wsel]) m_err[k] = 1'b1;
      if (iok && m_pend[k][isel] && !(wok && wsel == isel)) m_err[k] = 1'b1;
      if (wok) begin
        m_reg[k][wsel]  = wdata;
        m_pend[k][wsel] = 1'b0;
      end
      if (iok) m_pend[k][isel] = 1'b1;
    end
  endtask

  task automatic check_all();
    check_eq("d8 read1Data", 32'(rd1_a), 32'(exp_rd(0, r1)));
    check_eq("d8 read2Data", 32'(rd2_a), 32'(exp_rd(0, r2)));
    check_eq("d8 read1Busy", 32'(b1_a), 32'(exp_busy(0, r1)));
    check_eq("d8 read2Busy", 32'(b2_a), 32'(exp_busy(0, r2)));
    check_eq("d8 pendMask", 32'(pm_a), 32'(exp_pm(0)));
    check_eq("d8 err", 32'(err_a), 32'(rst ? 1'b0 : m_err[0]));
    check_eq("d6 read1Data", 32'(rd1_b), 32'(exp_rd(1, r1)));
    check_eq("d6 read2Data", 32'(rd2_b), 32'(exp_rd(1, r2)));
    check_eq("d6 read1Busy", 32'(b1_b), 32'(exp_busy(1, r1)));
    check_eq("d6 read2Busy", 32'(b2_b), 32'(exp_busy(1, r2)));
    check_eq("d6 pendMask", 32'({2'b00, pm_b}), 32'(exp_pm(1)));
    check_eq("d6 err", 32'(err_b), 32'(rst ? 1'b0 : m_err[1]));
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic cyc(input logic we_i, input logic [SW-1:0] wsel_i, input logic [W-1:0] wd_i,
                     input logic ie_i, input logic [SW-1:0] isel_i,
                     input logic [SW-1:0] r1_i, input logic [SW-1:0] r2_i);
    we = we_i; wsel = wsel_i; wdata = wd_i;
    ie = ie_i; isel = isel_i; r1 = r1_i; r2 = r2_i;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Reset asserted between edges with a write and issue pending on the same cycle.
  task automatic mid_reset(input logic [SW-1:0] r1_i);
    we = 1'b1; wsel = SW'($urandom_range(0, 7)); wdata = W'($urandom);
    ie = 1'b1; isel = SW'($urandom_range(0, 7)); r1 = r1_i; r2 = r1_i;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("rst read1Data immediate", 32'(rd1_a), 32'h0);
    check_eq("rst pendMask immediate", 32'(pm_a), 32'h0);
    check_eq("rst err immediate", 32'(err_a), 32'h0);
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;
    we = 1'b0; ie = 1'b0;
  endtask

  initial begin
    int pl[$];
    logic [SW-1:0] ws;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Mid-run reset wipes r3.
    cyc(1, 3, 16'hBEEF, 0, 0, 3, 3);
    cyc(0, 0, 16'h0,    0, 0, 3, 3);
    mid_reset(3);
    cyc(0, 0, 16'h0,    0, 0, 3, 3);

    // Issue then writeback of r5.
    cyc(0, 0, 16'h0,    1, 5, 5, 0);
    cyc(1, 5, 16'h1234, 0, 0, 5, 0);
    cyc(0, 0, 16'h0,    0, 0, 5, 0);

    // Simultaneous issue and writeback of pending r2.
    cyc(0, 0, 16'h0,    1, 2, 2, 2);
    cyc(1, 2, 16'h00AA, 1, 2, 2, 2);
    cyc(0, 0, 16'h0,    0, 0, 2, 2);

    // Orphan writeback to r1, then WAW double issue to r4.
    cyc(1, 1, 16'h7777, 0, 0, 1, 4);
    cyc(0, 0, 16'h0,    1, 4, 1, 4);
    cyc(0, 0, 16'h0,    1, 4, 1, 4);
    cyc(0, 0, 16'h0,    0, 0, 1, 4);
    mid_reset(0);

    // Out-of-range write and read selects (only out of range for the DEPTH=6 instance).
    cyc(0, 0, 16'h0,    1, 7, 6, 7);
    cyc(1, 7, 16'hCAFE, 0, 0, 6, 7);
    cyc(0, 0, 16'h0,    0, 0, 6, 7);
    mid_reset(6);

    // Same-cycle write and read of pending r0.
    cyc(0, 0, 16'h0,    1, 0, 1, 0);
    cyc(1, 0, 16'h5A5A, 0, 0, 1, 0);
    cyc(0, 0, 16'h0,    0, 0, 1, 0);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        mid_reset(SW'($urandom_range(0, 7)));
      end else begin
        pl.delete();
        for (int i = 0; i < 8; i++) if (m_pend[0][i]) pl.push_back(i);
        if (pl.size() != 0 && $urandom_range(0, 3) != 0)
          ws = SW'(pl[$urandom_range(0, pl.size() - 1)]);
        else
          ws = SW'($urandom_range(0, 7));
        cyc(logic'($urandom_range(0, 2) != 0), ws, W'($urandom),
            logic'($urandom_range(0, 2) == 0), SW'($urandom_range(0, 7)),
            SW'($urandom_range(0, 7)), ($urandom_range(0, 1) == 0) ? ws : SW'($urandom_range(0, 7)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
